// File: rtl/div_if.sv
// Request/response bundle between the CPU control and the iterative divider.
interface div_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             div_by_zero;

  modport master (
    output start, signed_op, a, b,
    input  busy, done, q, r, div_by_zero
  );

  modport slave (
    input  start, signed_op, a, b,
    output busy, done, q, r, div_by_zero
  );
endinterface

// File: rtl/multicycle_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, sign fix-up at the end,
// quotient/remainder registered and flagged by a one-cycle done pulse.
module multicycle_divider #(
  parameter int unsigned WIDTH = 32
) (
  input logic  clk,
  input logic  reset,
  div_if.slave bus
);
  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] a_orig;
  logic             sign_q, sign_r, zero_div;
  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             last;

  assign last     = (cnt == CW'(WIDTH - 1));
  assign bus.busy = (state != IDLE);
  // dvd shifts its MSB into the partial remainder and collects quotient bits at its LSB
  assign shifted  = {rem, dvd[WIDTH-1]};
  assign trial    = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = CALC;
      CALC:    if (last)      state_nxt = FIX;
      FIX:                    state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt             <= '0;
      rem             <= '0;
      dvd             <= '0;
      dvs             <= '0;
      a_orig          <= '0;
      sign_q          <= 1'b0;
      sign_r          <= 1'b0;
      zero_div        <= 1'b0;
      bus.done        <= 1'b0;
      bus.q           <= '0;
      bus.r           <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            cnt      <= '0;
            rem      <= '0;
            a_orig   <= bus.a;
            zero_div <= (bus.b == '0);
            if (bus.signed_op) begin
              dvd    <= bus.a[WIDTH-1] ? -bus.a : bus.a;
              dvs    <= bus.b[WIDTH-1] ? -bus.b : bus.b;
              sign_q <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
              sign_r <= bus.a[WIDTH-1];
            end else begin
              dvd    <= bus.a;
              dvs    <= bus.b;
              sign_q <= 1'b0;
              sign_r <= 1'b0;
            end
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          // rem < dvs holds throughout, so trial's MSB is a true sign bit
          if (!trial[WIDTH]) begin
            rem <= trial[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b1};
          end else begin
            rem <= shifted[WIDTH-1:0];
            dvd <= {dvd[WIDTH-2:0], 1'b0};
          end
        end
        FIX: begin
          bus.done        <= 1'b1;
          bus.div_by_zero <= zero_div;
          if (zero_div) begin
            bus.q <= '1;
            bus.r <= a_orig;
          end else begin
            bus.q <= sign_q ? -dvd : dvd;
            bus.r <= sign_r ? -rem : rem;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multicycle_divider.sv
// Directed checks of the divider: latency, signed/unsigned results, divide by zero,
// overflow, start-while-busy, back-to-back starts and mid-operation reset.
module tb_multicycle_divider;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  div_if #(.WIDTH(32)) bus ();

  multicycle_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present operands before a rising edge (edge N) and drop start just after it.
  task automatic start_op(input logic [31:0] av, input logic [31:0] bv, input logic sg);
    @(negedge clk);
    bus.a         = av;
    bus.b         = bv;
    bus.signed_op = sg;
    bus.start     = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges after the current point until done is seen, bounded.
  task automatic wait_done(output int edges);
    edges = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
    end while (!bus.done && edges < 100);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", bus.done); end
    checks++; if (bus.q !== 32'h0) begin errors++; $display("FAIL reset_q: got %h expected 0", bus.q); end
    checks++; if (bus.r !== 32'h0) begin errors++; $display("FAIL reset_r: got %h expected 0", bus.r); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz: got %b expected 0", bus.div_by_zero); end
    reset = 1'b1;
  endtask

  task automatic test_unsigned;
    int e;
    start_op(32'd100, 32'd7, 1'b0);
    checks++; if (bus.busy !== 1'b0 && bus.busy !== 1'b1) begin errors++; $display("FAIL u_busy_x: got %b", bus.busy); end
    @(posedge clk);
    #1;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL u_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL u_early_done: got %b expected 0", bus.done); end
    wait_done(e);
    checks++; if (e + 1 !== 33) begin errors++; $display("FAIL u_latency: got %0d expected 33", e + 1); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL u_busy_done: got %b expected 0", bus.busy); end
    checks++; if (bus.q !== 32'd14) begin errors++; $display("FAIL u_q: got %h expected %h", bus.q, 32'd14); end
    checks++; if (bus.r !== 32'd2) begin errors++; $display("FAIL u_r: got %h expected %h", bus.r, 32'd2); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL u_dbz: got %b expected 0", bus.div_by_zero); end
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL u_done_pulse: got %b expected 0", bus.done); end
    checks++; if (bus.q !== 32'd14) begin errors++; $display("FAIL u_q_hold: got %h expected %h", bus.q, 32'd14); end
  endtask

  task automatic test_signed;
    int e;
    start_op(32'hFFFFFF9C, 32'd7, 1'b1);
    wait_done(e);
    checks++; if (e !== 33) begin errors++; $display("FAIL s1_latency: got %0d expected 33", e); end
    checks++; if (bus.q !== 32'hFFFFFFF2) begin errors++; $display("FAIL s1_q: got %h expected FFFFFFF2", bus.q); end
    checks++; if (bus.r !== 32'hFFFFFFFE) begin errors++; $display("FAIL s1_r: got %h expected FFFFFFFE", bus.r); end
    start_op(32'd100, 32'hFFFFFFF9, 1'b1);
    wait_done(e);
    checks++; if (bus.q !== 32'hFFFFFFF2) begin errors++; $display("FAIL s2_q: got %h expected FFFFFFF2", bus.q); end
    checks++; if (bus.r !== 32'd2) begin errors++; $display("FAIL s2_r: got %h expected 00000002", bus.r); end
    start_op(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1);
    wait_done(e);
    checks++; if (bus.q !== 32'd14) begin errors++; $display("FAIL s3_q: got %h expected 0000000E", bus.q); end
    checks++; if (bus.r !== 32'hFFFFFFFE) begin errors++; $display("FAIL s3_r: got %h expected FFFFFFFE", bus.r); end
  endtask

  task automatic test_div_zero;
    int e;
    for (int m = 0; m < 2; m++) begin
      start_op(32'd5, 32'd0, m[0]);
      wait_done(e);
      checks++; if (e !== 33) begin errors++; $display("FAIL dz%0d_latency: got %0d expected 33", m, e); end
      checks++; if (bus.q !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz%0d_q: got %h expected FFFFFFFF", m, bus.q); end
      checks++; if (bus.r !== 32'd5) begin errors++; $display("FAIL dz%0d_r: got %h expected 00000005", m, bus.r); end
      checks++; if (bus.div_by_zero !== 1'b1) begin errors++; $display("FAIL dz%0d_flag: got %b expected 1", m, bus.div_by_zero); end
    end
    start_op(32'hFFFFFFFB, 32'd0, 1'b1);
    wait_done(e);
    checks++; if (bus.r !== 32'hFFFFFFFB) begin errors++; $display("FAIL dz_neg_r: got %h expected FFFFFFFB", bus.r); end
    checks++; if (bus.q !== 32'hFFFFFFFF) begin errors++; $display("FAIL dz_neg_q: got %h expected FFFFFFFF", bus.q); end
    start_op(32'd9, 32'd3, 1'b0);
    wait_done(e);
    checks++; if (bus.q !== 32'd3) begin errors++; $display("FAIL dz_after_q: got %h expected 00000003", bus.q); end
    checks++; if (bus.r !== 32'd0) begin errors++; $display("FAIL dz_after_r: got %h expected 0", bus.r); end
    checks++; if (bus.div_by_zero !== 1'b0) begin errors++; $display("FAIL dz_after_flag: got %b expected 0", bus.div_by_zero); end
  endtask

  task automatic test_overflow;
    int e;
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    wait_done(e);
    checks++; if (bus.q !== 32'h80000000) begin errors++; $display("FAIL ovf_s_q: got %h expected 80000000", bus.q); end
    checks++; if (bus.r !== 32'h0) begin errors++; $display("FAIL ovf_s_r: got %h expected 0", bus.r); end
    start_op(32'h80000000, 32'hFFFFFFFF, 1'b0);
    wait_done(e);
    checks++; if (bus.q !== 32'h0) begin errors++; $display("FAIL ovf_u_q: got %h expected 0", bus.q); end
    checks++; if (bus.r !== 32'h80000000) begin errors++; $display("FAIL ovf_u_r: got %h expected 80000000", bus.r); end
    start_op(32'hFFFFFFFF, 32'h10, 1'b0);
    wait_done(e);
    checks++; if (bus.q !== 32'h0FFFFFFF) begin errors++; $display("FAIL max_u_q: got %h expected 0FFFFFFF", bus.q); end
    checks++; if (bus.r !== 32'hF) begin errors++; $display("FAIL max_u_r: got %h expected 0000000F", bus.r); end
  endtask

  task automatic test_back_to_back;
    int e;
    start_op(32'd1000, 32'd10, 1'b0);
    for (int k = 1; k <= 32; k++) begin
      if (k == 5 || k == 20) begin
        bus.a = 32'd7; bus.b = 32'd2; bus.signed_op = 1'b1; bus.start = 1'b1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (k == 5 || k == 20) bus.a = 32'd77;
    end
    bus.start = 1'b0;
    @(posedge clk);
    #1;
    checks++; if (bus.done !== 1'b1) begin errors++; $display("FAIL bb_done: got %b expected 1", bus.done); end
    checks++; if (bus.q !== 32'd100) begin errors++; $display("FAIL bb_q: got %h expected 00000064", bus.q); end
    checks++; if (bus.r !== 32'd0) begin errors++; $display("FAIL bb_r: got %h expected 0", bus.r); end
    // Start in the done cycle itself.
    bus.a = 32'd50; bus.b = 32'd6; bus.signed_op = 1'b0; bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL bb2_busy: got %b expected 1", bus.busy); end
    checks++; if (bus.q !== 32'd100) begin errors++; $display("FAIL bb2_q_kept: got %h expected 00000064", bus.q); end
    wait_done(e);
    checks++; if (e !== 33) begin errors++; $display("FAIL bb2_latency: got %0d expected 33", e); end
    checks++; if (bus.q !== 32'd8) begin errors++; $display("FAIL bb2_q: got %h expected 00000008", bus.q); end
    checks++; if (bus.r !== 32'd2) begin errors++; $display("FAIL bb2_r: got %h expected 00000002", bus.r); end
  endtask

  task automatic test_reset_mid;
    int e;
    int seen;
    start_op(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL rm_done: got %b expected 0", bus.done); end
    checks++; if (bus.q !== 32'h0) begin errors++; $display("FAIL rm_q: got %h expected 0", bus.q); end
    checks++; if (bus.r !== 32'h0) begin errors++; $display("FAIL rm_r: got %h expected 0", bus.r); end
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("FAIL rm_no_done: got %0d active cycles expected 0", seen); end
    start_op(32'd9, 32'd3, 1'b0);
    wait_done(e);
    checks++; if (e !== 33) begin errors++; $display("FAIL rm_after_latency: got %0d expected 33", e); end
    checks++; if (bus.q !== 32'd3) begin errors++; $display("FAIL rm_after_q: got %h expected 00000003", bus.q); end
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    test_reset();
    test_unsigned();
    test_signed();
    test_div_zero();
    test_overflow();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
